// File: rtl/cell_config_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cell_config_loader: streams per-cell CLB control words into a shadow bank and
// commits the whole bank to the cell select outputs in one edge.  Rev 1.0
// ---------------------------------------------------------------------------
module cell_config_loader #(
  parameter int NUM_CELLS = 4,
  parameter int CFG_W     = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CFG_W-1:0]       cfg_word,
  output logic [NUM_CELLS-1:0]   cell_byPass,
  output logic [2*NUM_CELLS-1:0] cell_sel0,
  output logic [2*NUM_CELLS-1:0] cell_sel1,
  output logic [2*NUM_CELLS-1:0] cell_selOp,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                             state_q;
  logic [IDX_W-1:0]                   idx_q;
  logic [NUM_CELLS-1:0][CFG_W-1:0]    shadow_q;
  logic [NUM_CELLS-1:0]               bypass_q;
  logic [2*NUM_CELLS-1:0]             sel0_q;
  logic [2*NUM_CELLS-1:0]             sel1_q;
  logic [2*NUM_CELLS-1:0]             selop_q;
  logic                               done_q;
  logic                               xfer;

  // Ready is a pure state decode so upstream never sees a valid->ready loop.
  assign cfg_ready   = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign xfer        = cfg_valid & cfg_ready;
  assign done        = done_q;
  assign cell_byPass = bypass_q;
  assign cell_sel0   = sel0_q;
  assign cell_sel1   = sel1_q;
  assign cell_selOp  = selop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      bypass_q <= '0;
      sel0_q   <= '0;
      sel1_q   <= '0;
      selop_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
          end
        end
        S_LOAD: begin
          // Abort wins over a same-cycle transfer; that word is dropped.
          if (abort) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
          end else if (xfer) begin
            shadow_q[idx_q] <= cfg_word;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= S_COMMIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < NUM_CELLS; k++) begin
            bypass_q[k]       <= shadow_q[k][6];
            sel0_q[2*k +: 2]  <= shadow_q[k][5:4];
            sel1_q[2*k +: 2]  <= shadow_q[k][3:2];
            selop_q[2*k +: 2] <= shadow_q[k][1:0];
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cell_config_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cell_config_loader: directed bench for cell_config_loader (4-cell and
// 1-cell instances) with hand-computed expected configurations.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_cell_config_loader;

  logic       clk;
  logic       rst_n;
  logic       start, abort, cfg_valid;
  logic [6:0] cfg_word;
  logic       cfg_ready, busy, done;
  logic [3:0] cell_byPass;
  logic [7:0] cell_sel0, cell_sel1, cell_selOp;

  logic       start1, abort1, cfg_valid1;
  logic [6:0] cfg_word1;
  logic       cfg_ready1, busy1, done1;
  logic [0:0] cell_byPass1;
  logic [1:0] cell_sel0_1, cell_sel1_1, cell_selOp_1;

  int n_checks;
  int n_errors;

  cell_config_loader #(.NUM_CELLS(4), .CFG_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_word(cfg_word),
    .cell_byPass(cell_byPass), .cell_sel0(cell_sel0), .cell_sel1(cell_sel1),
    .cell_selOp(cell_selOp), .busy(busy), .done(done)
  );

  cell_config_loader #(.NUM_CELLS(1), .CFG_W(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1), .cfg_word(cfg_word1),
    .cell_byPass(cell_byPass1), .cell_sel0(cell_sel0_1), .cell_sel1(cell_sel1_1),
    .cell_selOp(cell_selOp_1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cfg(input string pfx, input logic [3:0] bp, input logic [7:0] s0,
                           input logic [7:0] s1, input logic [7:0] op);
    check({pfx, ".byPass"}, cell_byPass, bp);
    check({pfx, ".sel0"},   cell_sel0,   s0);
    check({pfx, ".sel1"},   cell_sel1,   s1);
    check({pfx, ".selOp"},  cell_selOp,  op);
  endtask

  // Start a load, present 4 words under a valid pattern (valid=1 once the
  // pattern runs out), and return the number of edges from start to done.
  task automatic run_load(input string pfx, input logic [27:0] words, input logic [15:0] vpat,
                          input int vlen, output int cyc);
    logic [3:0] bp0;
    logic [7:0] s00, s10, op0;
    int  wi;
    bit  seen, held;
    bp0 = cell_byPass; s00 = cell_sel0; s10 = cell_sel1; op0 = cell_selOp;
    wi = 0; seen = 0; held = 1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (wi < 4) begin
        cfg_valid = (c < vlen) ? vpat[c] : 1'b1;
        cfg_word  = cfg_valid ? words[wi*7 +: 7] : 7'h7F;
      end else begin
        cfg_valid = 1'b0;
      end
      check({pfx, ".ready"}, cfg_ready, (wi < 4));
      if (cfg_valid) wi++;
      tick;
      cyc++;
      if (done) seen = 1;
      else if (cell_byPass !== bp0 || cell_sel0 !== s00 || cell_sel1 !== s10 || cell_selOp !== op0)
        held = 0;
    end
    cfg_valid = 1'b0;
    check({pfx, ".held_until_done"}, held, 1'b1);
    check({pfx, ".done_seen"}, seen, 1'b1);
  endtask

  int cyc;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    start = 0; abort = 0; cfg_valid = 0; cfg_word = '0;
    start1 = 0; abort1 = 0; cfg_valid1 = 0; cfg_word1 = '0;
    tick; tick;
    check("rst.busy", busy, 1'b0);
    check("rst.ready", cfg_ready, 1'b0);
    check("rst.done", done, 1'b0);
    check_cfg("rst", 4'h0, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick;

    // Full load, valid held high
    run_load("full", {7'h3F, 7'h2A, 7'h15, 7'h40}, 16'hFFFF, 16, cyc);
    check("full.latency", cyc, 6);
    check_cfg("full", 4'b0001, 8'hE4, 8'hE4, 8'hE4);
    tick;
    check("full.done_once", done, 1'b0);
    check("full.busy_after", busy, 1'b0);

    // Back-pressure: valid 1,0,0,1,1,0,1
    run_load("bp", {7'h3B, 7'h64, 7'h12, 7'h01}, 16'b1011001, 7, cyc);
    check("bp.latency", cyc, 9);
    check_cfg("bp", 4'b0100, 8'hE4, 8'h90, 8'hC9);
    tick;

    // Abort on the 3rd transfer
    start = 1'b1; tick; start = 1'b0;
    cfg_valid = 1'b1; cfg_word = 7'h7F; tick;
    tick;
    abort = 1'b1; tick;
    abort = 1'b0; cfg_valid = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.ready", cfg_ready, 1'b0);
    check("abort.done", done, 1'b0);
    check_cfg("abort", 4'b0100, 8'hE4, 8'h90, 8'hC9);
    tick;
    check("abort.no_done", done, 1'b0);
    run_load("reload", {7'h3F, 7'h2A, 7'h15, 7'h40}, 16'hFFFF, 16, cyc);
    check_cfg("reload", 4'b0001, 8'hE4, 8'hE4, 8'hE4);
    tick;

    // Ignored controls
    cfg_valid = 1'b1; cfg_word = 7'h7F;
    check("idle.ready", cfg_ready, 1'b0);
    tick; tick;
    check("idle.busy", busy, 1'b0);
    check("idle.done", done, 1'b0);
    cfg_valid = 1'b0; abort = 1'b1; tick;
    check("idle_abort.busy", busy, 1'b0);
    abort = 1'b0;
    start = 1'b1; tick;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_word = 7'h2A; start = 1'b1;
      tick;
    end
    check("commit.busy", busy, 1'b1);
    check("commit.ready", cfg_ready, 1'b0);
    abort = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_word = 7'h7F;
    tick;
    check("commit.done", done, 1'b1);
    check("commit.busy_after", busy, 1'b0);
    check_cfg("ign", 4'b0000, 8'hAA, 8'hAA, 8'hAA);
    cfg_valid = 1'b0;
    tick;
    check("start_abort_idle.busy", busy, 1'b1);
    start = 1'b0; tick;
    check("load_abort.busy", busy, 1'b0);
    abort = 1'b0;
    check_cfg("ign_hold", 4'b0000, 8'hAA, 8'hAA, 8'hAA);

    // Asynchronous reset mid-load after 2 words
    start = 1'b1; tick; start = 1'b0;
    cfg_valid = 1'b1; cfg_word = 7'h55; tick; tick;
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", busy, 1'b0);
    check("arst.ready", cfg_ready, 1'b0);
    check("arst.done", done, 1'b0);
    check_cfg("arst", 4'h0, 8'h00, 8'h00, 8'h00);
    tick;
    rst_n = 1'b1;
    tick;
    run_load("post_rst", {7'h3B, 7'h64, 7'h12, 7'h01}, 16'hFFFF, 16, cyc);
    check("post_rst.latency", cyc, 6);
    check_cfg("post_rst", 4'b0100, 8'hE4, 8'h90, 8'hC9);

    // Single-cell instance
    check("one.rst_bp", cell_byPass1, 1'b0);
    start1 = 1'b1; tick; start1 = 1'b0;
    check("one.ready", cfg_ready1, 1'b1);
    cfg_valid1 = 1'b1; cfg_word1 = 7'h7F; tick;
    cfg_valid1 = 1'b0;
    check("one.early_done", done1, 1'b0);
    check("one.commit_ready", cfg_ready1, 1'b0);
    tick;
    check("one.done", done1, 1'b1);
    check("one.byPass", cell_byPass1, 1'b1);
    check("one.sel0", cell_sel0_1, 2'b11);
    check("one.sel1", cell_sel1_1, 2'b11);
    check("one.selOp", cell_selOp_1, 2'b11);
    tick;
    check("one.done_once", done1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
